// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch unit: instruction field constants,
// the ALU function encoding, the control FSM state encoding and a small
// decoder that classifies an instruction word.
package branch_unit_pkg;

  // Major opcodes handled by the unit
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 values
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // The only ALU function this unit ever requests
  localparam logic [2:0] ALU_OP_ADD = 3'b000;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_ALU    = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Instruction class after decode
  typedef enum logic [1:0] {
    KIND_ILLEGAL = 2'd0,
    KIND_JAL     = 2'd1,
    KIND_JALR    = 2'd2,
    KIND_BRANCH  = 2'd3
  } kind_e;

  function automatic kind_e decode_kind(input logic [31:0] instr);
    logic [6:0] opc;
    logic [2:0] f3;
    kind_e      kind;
    opc  = instr[6:0];
    f3   = instr[14:12];
    kind = KIND_ILLEGAL;
    case (opc)
      OPC_JAL:    kind = KIND_JAL;
      OPC_JALR:   if (f3 == F3_JALR) kind = KIND_JALR;
      OPC_BRANCH: if (f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU})
                    kind = KIND_BRANCH;
      default:    kind = KIND_ILLEGAL;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/branch_unit_if.sv
// ALU request channel between the branch unit (master) and the shared
// ALU (slave).
//   alu_a/alu_b  operands
//   alu_op       ALU function
//   alu_signal   ALU modifier
//   alu_valid    request valid
//   alu_ready    ALU accepts the request
//   alu_out      ALU result
// Handshake: the master raises alu_valid with alu_a/alu_b/alu_op/alu_signal
// and must hold all of them stable until a cycle in which alu_ready=1; that
// cycle is the transfer, and alu_out is valid in that same cycle. The slave
// may assert alu_ready only while alu_valid=1.
interface branch_unit_if #(
  parameter int XLEN = 32
) ();
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [2:0]      alu_op;
  logic            alu_signal;
  logic            alu_valid;
  logic            alu_ready;
  logic [XLEN-1:0] alu_out;

  modport master (
    output alu_a, alu_b, alu_op, alu_signal, alu_valid,
    input  alu_ready, alu_out
  );

  modport slave (
    input  alu_a, alu_b, alu_op, alu_signal, alu_valid,
    output alu_ready, alu_out
  );
endinterface

// File: rtl/branch_unit_compare.sv
// Branch condition evaluation for conditional branches.
//   funct3  branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   rs1/rs2 register operands
//   taken   condition result; 0 for any non-branch funct3
module branch_compare
  import branch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);
  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = !lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_unit.sv
// Branch/jump execution unit. Accepts one JAL/JALR/Bxx instruction at a
// time, reads its source registers, computes the target on the shared ALU
// and reports redirect / link writeback / faults in a single COMMIT cycle.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   enable_n                   active-low request, taken only while idle
//   instruction, program_counter  latched on accept
//   busy                       high from the cycle after accept through COMMIT
//   done                       one-cycle pulse in COMMIT
//   register_src_a/_b          rs1/rs2 selects (READ only)
//   register_src_a/_b_data     register file data, sampled at end of READ
//   alu                        ALU request channel (master side)
//   load_new_program_counter, new_program_counter   redirect (COMMIT only)
//   output_register, output_register_data, write_enable  link writeback
//   misaligned, illegal        fault flags (COMMIT only)
//   fsm_state                  current control state, for observation
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_SELECT_LEN = 5,
  parameter int COMPRESSED     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable_n,
  input  logic [31:0]               instruction,
  input  logic [XLEN-1:0]           program_counter,
  output logic                      busy,
  output logic                      done,
  output logic [REG_SELECT_LEN-1:0] register_src_a,
  output logic [REG_SELECT_LEN-1:0] register_src_b,
  input  logic [XLEN-1:0]           register_src_a_data,
  input  logic [XLEN-1:0]           register_src_b_data,
  branch_unit_if.master             alu,
  output logic                      load_new_program_counter,
  output logic [XLEN-1:0]           new_program_counter,
  output logic [REG_SELECT_LEN-1:0] output_register,
  output logic [XLEN-1:0]           output_register_data,
  output logic                      write_enable,
  output logic                      misaligned,
  output logic                      illegal,
  output logic [1:0]                fsm_state
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] READ   = ST_READ;
  localparam logic [1:0] ALU    = ST_ALU;
  localparam logic [1:0] COMMIT = ST_COMMIT;

  logic [1:0]      state;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] target_q;

  kind_e           in_kind;
  kind_e           kind_q;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            br_taken;
  logic            taken;
  logic            is_jump;
  logic [XLEN-1:0] target;
  logic            target_misaligned;
  logic [XLEN-1:0] link_addr;
  logic [4:0]      rd;

  assign in_kind = decode_kind(instruction);
  assign kind_q  = decode_kind(instr_q);
  assign rd      = instr_q[11:7];

  // Sign-extended immediates of the latched instruction
  assign imm_i = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign imm_j = {{(XLEN-21){instr_q[31]}}, instr_q[31], instr_q[19:12],
                  instr_q[20], instr_q[30:21], 1'b0};
  assign imm_b = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                  instr_q[30:25], instr_q[11:8], 1'b0};

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      instr_q  <= '0;
      pc_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      target_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!enable_n) begin
            instr_q <= instruction;
            pc_q    <= program_counter;
            case (in_kind)
              KIND_ILLEGAL: state <= COMMIT;
              KIND_JAL:     state <= ALU;
              default:      state <= READ;
            endcase
          end
        end
        READ: begin
          rs1_q <= register_src_a_data;
          rs2_q <= register_src_b_data;
          state <= ALU;
        end
        ALU: begin
          if (alu.alu_ready) begin
            target_q <= alu.alu_out;
            state    <= COMMIT;
          end
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ALU operands depend only on latched state, so they stay stable while
  // the request waits for alu_ready.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (kind_q)
      KIND_JAL: begin
        op_a = pc_q;
        op_b = imm_j;
      end
      KIND_JALR: begin
        op_a = rs1_q;
        op_b = imm_i;
      end
      KIND_BRANCH: begin
        op_a = pc_q;
        op_b = imm_b;
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  branch_compare #(.XLEN(XLEN)) u_compare (
    .funct3 (instr_q[14:12]),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .taken  (br_taken)
  );

  assign is_jump = (kind_q == KIND_JAL) || (kind_q == KIND_JALR);
  assign taken   = is_jump || ((kind_q == KIND_BRANCH) && br_taken);

  // JALR drops bit 0 of the computed address; other targets pass through
  assign target = (kind_q == KIND_JALR) ? {target_q[XLEN-1:1], 1'b0} : target_q;
  assign target_misaligned = (COMPRESSED == 0) && target[1];
  assign link_addr = pc_q + XLEN'(4);

  // Outputs are decoded from the state; every output is 0 outside the
  // state that owns it.
  always_comb begin
    busy                     = (state != IDLE);
    done                     = 1'b0;
    register_src_a           = '0;
    register_src_b           = '0;
    alu.alu_a                = '0;
    alu.alu_b                = '0;
    alu.alu_op               = ALU_OP_ADD;
    alu.alu_signal           = 1'b0;
    alu.alu_valid            = 1'b0;
    load_new_program_counter = 1'b0;
    new_program_counter      = '0;
    output_register          = '0;
    output_register_data     = '0;
    write_enable             = 1'b0;
    misaligned               = 1'b0;
    illegal                  = 1'b0;
    fsm_state                = state;
    case (state)
      READ: begin
        register_src_a = REG_SELECT_LEN'(instr_q[19:15]);
        register_src_b = REG_SELECT_LEN'(instr_q[24:20]);
      end
      ALU: begin
        alu.alu_valid = 1'b1;
        alu.alu_a     = op_a;
        alu.alu_b     = op_b;
      end
      COMMIT: begin
        done = 1'b1;
        if (kind_q == KIND_ILLEGAL) begin
          illegal = 1'b1;
        end else if (taken) begin
          // Target is reported even when misaligned; only the redirect
          // and the link writeback are suppressed.
          new_program_counter = target;
          if (target_misaligned) begin
            misaligned = 1'b1;
          end else begin
            load_new_program_counter = 1'b1;
            if (is_jump && (rd != 5'd0)) begin
              write_enable         = 1'b1;
              output_register      = REG_SELECT_LEN'(rd);
              output_register_data = link_addr;
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;
  localparam int XLEN = 32;
  localparam int RSL  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            enable_n;
  logic [31:0]     instruction;
  logic [XLEN-1:0] program_counter;
  logic            busy;
  logic            done;
  logic [RSL-1:0]  register_src_a;
  logic [RSL-1:0]  register_src_b;
  logic [XLEN-1:0] register_src_a_data;
  logic [XLEN-1:0] register_src_b_data;
  logic            load_new_program_counter;
  logic [XLEN-1:0] new_program_counter;
  logic [RSL-1:0]  output_register;
  logic [XLEN-1:0] output_register_data;
  logic            write_enable;
  logic            misaligned;
  logic            illegal;
  logic [1:0]      fsm_state;

  branch_unit_if #(.XLEN(XLEN)) alu_bus ();

  branch_unit #(.XLEN(XLEN), .REG_SELECT_LEN(RSL), .COMPRESSED(0)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable_n                 (enable_n),
    .instruction              (instruction),
    .program_counter          (program_counter),
    .busy                     (busy),
    .done                     (done),
    .register_src_a           (register_src_a),
    .register_src_b           (register_src_b),
    .register_src_a_data      (register_src_a_data),
    .register_src_b_data      (register_src_b_data),
    .alu                      (alu_bus.master),
    .load_new_program_counter (load_new_program_counter),
    .new_program_counter      (new_program_counter),
    .output_register          (output_register),
    .output_register_data     (output_register_data),
    .write_enable             (write_enable),
    .misaligned               (misaligned),
    .illegal                  (illegal),
    .fsm_state                (fsm_state)
  );

  // ---------------- environment models ----------------
  logic [XLEN-1:0] rf [32];
  assign register_src_a_data = rf[register_src_a];
  assign register_src_b_data = rf[register_src_b];

  int alu_delay;
  int wait_cnt;
  assign alu_bus.alu_out   = alu_bus.alu_a + alu_bus.alu_b;
  assign alu_bus.alu_ready = alu_bus.alu_valid && (wait_cnt >= alu_delay);
  always @(posedge clk)
    wait_cnt <= (alu_bus.alu_valid && !alu_bus.alu_ready) ? wait_cnt + 1 : 0;

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic            alu_seen;
  logic            alu_unstable;
  int              alu_cycles;
  logic [XLEN-1:0] alu_a_cap;
  logic [XLEN-1:0] alu_b_cap;
  logic [2:0]      alu_op_cap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input int dly);
    alu_delay       = dly;
    instruction     = instr;
    program_counter = pc;
    enable_n        = 1'b0;
    @(negedge clk);
    enable_n = 1'b1;
  endtask

  // Leaves the bench at the COMMIT-cycle sampling point
  task automatic wait_commit(input string tag);
    alu_seen     = 1'b0;
    alu_unstable = 1'b0;
    alu_cycles   = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) break;
      if (alu_bus.alu_valid) begin
        if (alu_seen && (alu_bus.alu_a !== alu_a_cap || alu_bus.alu_b !== alu_b_cap))
          alu_unstable = 1'b1;
        if (!alu_seen) begin
          alu_a_cap  = alu_bus.alu_a;
          alu_b_cap  = alu_bus.alu_b;
          alu_op_cap = alu_bus.alu_op;
        end
        alu_seen = 1'b1;
        alu_cycles++;
      end
      @(negedge clk);
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
  endtask

  task automatic check_commit(input string tag, input logic ld, input logic we,
                              input logic [4:0] rd, input logic [31:0] wd,
                              input logic mis, input logic ill);
    logic [31:0] exp_npc;
    exp_npc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    chk({tag, ".load"}, 32'(load_new_program_counter), 32'(ld));
    chk({tag, ".npc"},  new_program_counter, exp_npc);
    chk({tag, ".we"},   32'(write_enable), 32'(we));
    chk({tag, ".rd"},   32'(output_register), 32'(rd));
    chk({tag, ".wd"},   output_register_data, wd);
    chk({tag, ".mis"},  32'(misaligned), 32'(mis));
    chk({tag, ".ill"},  32'(illegal), 32'(ill));
    chk({tag, ".busy_commit"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, ".done_drop"}, 32'(done), 32'd0);
    chk({tag, ".busy_drop"}, 32'(busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[2] = 32'h0000_1003;
    rf[3] = 32'hFFFF_FFFF;
    rf[4] = 32'h0000_0001;
    reset           = 1'b1;
    enable_n        = 1'b1;
    instruction     = '0;
    program_counter = '0;
    alu_delay       = 0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst.busy",  32'(busy), 32'd0);
    chk("rst.done",  32'(done), 32'd0);
    chk("rst.valid", 32'(alu_bus.alu_valid), 32'd0);
    chk("rst.state", 32'(fsm_state), 32'd0);
    reset = 1'b0;

    // JALR x1, 4(x2), x2=0x1003 -> 0x1006, misaligned, no redirect/writeback
    exp_q.push_back(32'h0000_1006);
    issue(32'h0041_00E7, 32'h0000_0200, 0);
    chk("jalr.busy", 32'(busy), 32'd1);
    wait_commit("jalr");
    chk("jalr.alu_a", alu_a_cap, 32'h0000_1003);
    chk("jalr.alu_b", alu_b_cap, 32'h0000_0004);
    check_commit("jalr", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // JAL x5, -8 at 0x100, ALU ready after 3 waiting cycles
    exp_q.push_back(32'h0000_00F8);
    issue(32'hFF9F_F2EF, 32'h0000_0100, 3);
    wait_commit("jal");
    chk("jal.alu_a",    alu_a_cap, 32'h0000_0100);
    chk("jal.alu_b",    alu_b_cap, 32'hFFFF_FFF8);
    chk("jal.alu_op",   32'(alu_op_cap), 32'd0);
    chk("jal.alu_cyc",  32'(alu_cycles), 32'd4);
    chk("jal.stable",   32'(alu_unstable), 32'd0);
    check_commit("jal", 1'b1, 1'b1, 5'd5, 32'h0000_0104, 1'b0, 1'b0);

    // BLT x3, x4, +16: -1 < 1 signed -> taken
    exp_q.push_back(32'h0000_0310);
    issue(32'h0041_C863, 32'h0000_0300, 0);
    wait_commit("blt");
    check_commit("blt", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // BLTU x3, x4, +16: 0xFFFFFFFF < 1 unsigned is false -> done only
    exp_q.push_back(32'h0000_0000);
    issue(32'h0041_E863, 32'h0000_0300, 1);
    wait_commit("bltu");
    check_commit("bltu", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // JAL x0, +8 at 0x400: redirect, no writeback
    exp_q.push_back(32'h0000_0408);
    issue(32'h0080_006F, 32'h0000_0400, 0);
    wait_commit("jal0");
    check_commit("jal0", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // opcode 0110011 -> illegal, never requests the ALU
    exp_q.push_back(32'h0000_0000);
    issue(32'h0031_00B3, 32'h0000_0500, 0);
    wait_commit("ill");
    chk("ill.no_alu", 32'(alu_seen), 32'd0);
    check_commit("ill", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

    // reset while an ALU request is pending
    issue(32'hFF9F_F2EF, 32'h0000_0100, 1000);
    for (int i = 0; i < 10 && !alu_bus.alu_valid; i++) @(negedge clk);
    chk("rstmid.valid_before", 32'(alu_bus.alu_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid.busy",  32'(busy), 32'd0);
    chk("rstmid.valid", 32'(alu_bus.alu_valid), 32'd0);
    chk("rstmid.alu_a", alu_bus.alu_a, 32'h0);
    chk("rstmid.state", 32'(fsm_state), 32'd0);
    chk("rstmid.load",  32'(load_new_program_counter), 32'd0);
    chk("rstmid.we",    32'(write_enable), 32'd0);
    reset = 1'b0;
    exp_q.push_back(32'h0000_0310);
    issue(32'h0041_C863, 32'h0000_0300, 0);
    chk("rstmid.accept", 32'(busy), 32'd1);
    wait_commit("rstmid");
    check_commit("rstmid", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // enable_n held low: second instruction waits until after COMMIT
    exp_q.push_back(32'h0000_0310);
    exp_q.push_back(32'h0000_0408);
    alu_delay       = 2;
    instruction     = 32'h0041_C863;
    program_counter = 32'h0000_0300;
    enable_n        = 1'b0;
    @(negedge clk);
    instruction     = 32'h0080_006F;
    program_counter = 32'h0000_0400;
    wait_commit("hold1");
    chk("hold1.npc", new_program_counter, exp_q.pop_front());
    @(negedge clk);
    chk("hold.idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    enable_n = 1'b1;
    chk("hold.accept2", 32'(busy), 32'd1);
    wait_commit("hold2");
    check_commit("hold2", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
